lfsr_share_arbiter: RTL and testbench



---
 rtl/lfsr_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_lfsr_share_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_share_arbiter.sv
// Shares one external 8-bit LFSR among NUM_REQ requesters, round-robin.
// Optional draw/stall counters: define LFSR_SHARE_ARBITER_STATS_EN.
module lfsr_share_arbiter #(
  parameter int         NUM_REQ       = 4,
  parameter logic [7:0] DEFAULT_SEED  = 8'hA5,
  parameter int         WARMUP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         cfg_seed,
  input  logic               cfg_seed_load,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [7:0]         rnd_data,
  output logic               busy,
  output logic               lfsr_resetn,
  output logic [7:0]         lfsr_seed,
  output logic               lfsr_next,
  input  logic [7:0]         lfsr_value
`ifdef LFSR_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]        draw_count,
  output logic [15:0]        stall_count
`endif
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    SEED,
    WARMUP,
    SERVE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      seed_q, seed_d;
  logic [7:0]      warm_q, warm_d;
  logic [RR_W-1:0] rr_q, rr_d;

  logic            gnt_found;
  logic [RR_W-1:0] gnt_idx;
  logic [RR_W-1:0] gnt_nxt;

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    int k;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = RR_W'(k);
      end
    end
    k = int'(gnt_idx) + 1;
    if (k >= NUM_REQ) k = 0;
    gnt_nxt = RR_W'(k);
  end

  // Next-state and output decode for the seed/warm-up/serve sequence.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    warm_d      = warm_q;
    rr_d        = rr_q;
    req_ready   = '0;
    rnd_data    = 8'h00;
    lfsr_next   = 1'b0;
    busy        = 1'b1;
    lfsr_resetn = 1'b1;
    lfsr_seed   = seed_q;
    unique case (state_q)
      SEED: begin
        lfsr_resetn = 1'b0;
        state_d     = WARMUP;
        warm_d      = 8'h00;
      end
      WARMUP: begin
        lfsr_next = 1'b1;
        if (warm_q == WARM_LAST) state_d = SERVE;
        else warm_d = warm_q + 8'h01;
      end
      SERVE: begin
        busy = 1'b0;
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          rnd_data           = lfsr_value;
          lfsr_next          = 1'b1;
          rr_d               = gnt_nxt;
        end
      end
      default: state_d = SEED;
    endcase
    if (cfg_seed_load) begin
      seed_d    = (cfg_seed == 8'h00) ? DEFAULT_SEED : cfg_seed;
      state_d   = SEED;
      rr_d      = rr_q;
      req_ready = '0;
      rnd_data  = 8'h00;
      lfsr_next = 1'b0;
    end
    if (!resetn) begin
      req_ready   = '0;
      rnd_data    = 8'h00;
      lfsr_next   = 1'b0;
      busy        = 1'b1;
      lfsr_resetn = 1'b0;
      lfsr_seed   = DEFAULT_SEED;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SEED;
      seed_q  <= DEFAULT_SEED;
      warm_q  <= 8'h00;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      warm_q  <= warm_d;
      rr_q    <= rr_d;
    end
  end

`ifdef LFSR_SHARE_ARBITER_STATS_EN
  logic [15:0] draw_q, stall_q;
  logic        any_req, any_gnt;

  assign any_req     = |req_valid;
  assign any_gnt     = |(req_valid & req_ready);
  assign draw_count  = draw_q;
  assign stall_count = stall_q;

  // Saturating completed-draw and stalled-request counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      draw_q  <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      if (any_gnt && draw_q != 16'hFFFF)
        draw_q <= draw_q + 16'h0001;
      if (any_req && !any_gnt && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Scoreboard bench for lfsr_share_arbiter with an attached LFSR model.
// Reference model works in cycles-since-seed and draw counts.
module tb_lfsr_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam logic [7:0] DSEED = 8'hA5;

  logic         clk = 1'b0;
  logic         resetn;
  logic [7:0]   cfg_seed;
  logic         cfg_seed_load;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [7:0]   rnd_data;
  logic         busy;
  logic         lfsr_resetn;
  logic [7:0]   lfsr_seed;
  logic         lfsr_next;
  logic [7:0]   lfsr_value = 8'h00;
`ifdef LFSR_SHARE_ARBITER_STATS_EN
  logic [15:0]  draw_count;
  logic [15:0]  stall_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_share_arbiter #(
    .NUM_REQ(N), .DEFAULT_SEED(DSEED), .WARMUP_CYCLES(W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_seed(cfg_seed), .cfg_seed_load(cfg_seed_load),
    .req_valid(req_valid), .req_ready(req_ready),
    .rnd_data(rnd_data), .busy(busy),
    .lfsr_resetn(lfsr_resetn), .lfsr_seed(lfsr_seed),
    .lfsr_next(lfsr_next), .lfsr_value(lfsr_value)
`ifdef LFSR_SHARE_ARBITER_STATS_EN
    , .draw_count(draw_count), .stall_count(stall_count)
`endif
  );

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] pow(input logic [7:0] s, input int n);
    logic [7:0] v = s;
    for (int i = 0; i < n; i++) v = step(v);
    return v;
  endfunction

  // LFSR primitive the arbiter drives.
  always @(posedge clk) begin
    if (!lfsr_resetn) lfsr_value <= lfsr_seed;
    else if (lfsr_next) lfsr_value <= step(lfsr_value);
  end

  typedef struct {
    logic [N-1:0] rdy;
    logic [7:0]   data;
    logic         nxt;
    logic         bsy;
    logic         lres;
    logic [7:0]   seed;
  } exp_t;

  exp_t q[$];

  logic [7:0] m_seed;
  logic [7:0] m_cur;
  int         m_phase;
  int         m_rr;
  int         m_draws;
  int         m_stalls;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rn, input logic ld,
                       input logic [7:0] sd, input logic [N-1:0] v);
    exp_t e;
    int g;
    @(posedge clk);
    #1;
    resetn        = rn;
    cfg_seed_load = ld;
    cfg_seed      = sd;
    req_valid     = v;
    g = -1;
    for (int off = N - 1; off >= 0; off--)
      if (v[(m_rr + off) % N]) g = (m_rr + off) % N;
    e.rdy = '0; e.data = 8'h00; e.nxt = 1'b0;
    e.bsy = 1'b1; e.lres = 1'b1; e.seed = m_seed;
    if (!rn) begin
      e.lres = 1'b0;
      e.seed = DSEED;
    end else if (m_phase == 0) begin
      e.lres = 1'b0;
    end else if (m_phase <= W) begin
      e.nxt = !ld;
    end else begin
      e.bsy = 1'b0;
      if (!ld && g >= 0) begin
        e.rdy[g] = 1'b1;
        e.data   = m_cur;
        e.nxt    = 1'b1;
      end
    end
    q.push_back(e);
    if (!rn) begin
      m_seed = DSEED; m_phase = 0; m_rr = 0;
      m_draws = 0; m_stalls = 0;
      m_cur = pow(DSEED, W);
    end else if (ld) begin
      m_seed  = (sd == 8'h00) ? DSEED : sd;
      m_cur   = pow(m_seed, W);
      m_phase = 0;
      if (v != '0) m_stalls++;
    end else if (m_phase <= W) begin
      m_phase++;
      if (v != '0) m_stalls++;
    end else if (g >= 0) begin
      m_rr  = (g + 1) % N;
      m_cur = step(m_cur);
      m_draws++;
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("req_ready", int'(req_ready), int'(e.rdy));
        chk("rnd_data", int'(rnd_data), int'(e.data));
        chk("lfsr_next", int'(lfsr_next), int'(e.nxt));
        chk("busy", int'(busy), int'(e.bsy));
        chk("lfsr_resetn", int'(lfsr_resetn), int'(e.lres));
        if (!e.lres) chk("lfsr_seed", int'(lfsr_seed), int'(e.seed));
      end
    end
  end

  initial begin
    resetn = 1'b0; cfg_seed_load = 1'b0;
    cfg_seed = 8'h00; req_valid = '0;
    m_seed = DSEED; m_phase = 0; m_rr = 0;
    m_draws = 0; m_stalls = 0; m_cur = pow(DSEED, W);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 4'b1111);
    repeat (30) cycle(1'b1, 1'b0, 8'h00, 4'b1111);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 1'b0, 8'h00, (i % 3 == 2) ? 4'b0000 : 4'b1010);
    repeat (60) cycle(1'b1, 1'b0, 8'h00, N'($urandom));
    cycle(1'b1, 1'b1, 8'h00, 4'b1111);
    repeat (15) cycle(1'b1, 1'b0, 8'h00, N'($urandom));
    cycle(1'b1, 1'b1, 8'h5A, 4'b0110);
    repeat (4) cycle(1'b1, 1'b0, 8'h00, 4'b0110);
    cycle(1'b1, 1'b1, 8'h3C, 4'b0000);
    repeat (25) cycle(1'b1, 1'b0, 8'h00, 4'b1111);
    repeat (2) cycle(1'b0, 1'b1, 8'h77, 4'b1111);
    repeat (40) cycle(1'b1, 1'b0, 8'h00, N'($urandom));
    for (int i = 0; i < 300; i++) begin
      logic rn, ld;
      logic [7:0] sd;
      rn = ($urandom_range(0, 99) != 0);
      ld = ($urandom_range(0, 39) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle(rn, ld, sd, N'($urandom));
    end
`ifdef LFSR_SHARE_ARBITER_STATS_EN
    repeat (70000) cycle(1'b1, 1'b0, 8'h00, 4'b1111);
`endif
    cycle(1'b1, 1'b0, 8'h00, 4'b0000);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
`ifdef LFSR_SHARE_ARBITER_STATS_EN
    chk("draw_count", int'(draw_count),
        (m_draws > 65535) ? 65535 : m_draws);
    chk("stall_count", int'(stall_count),
        (m_stalls > 65535) ? 65535 : m_stalls);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
